cpu_execute_muldiv: RTL and testbench

Parametrised multi-cycle execution unit for the RV32M/RV64M complex-op class: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Replaces the fixed-width, tag-compare complex path of the execute stage with an explicit valid/ready handshake.
- Widths, multiplier pipeline depth and divider bits-per-cycle are configurable.
- Adds MULHSU, the RISC-V divide-by-zero and overflow fast paths, and a pipeline flush.
- Sits beside the ALU inside execute; execute stalls its own issue on o_ready.

---
 rtl/cpu_muldiv_pkg.sv | 28 ++
 rtl/cpu_muldiv_divider_core.sv | 57 +++++
 rtl/cpu_execute_muldiv.sv | 134 +++++++++++++
 tb/tb_cpu_execute_muldiv.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_muldiv_pkg.sv
// cpu_muldiv_pkg: op/state encodings and op-class helpers for the multiply/divide unit
package cpu_muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE
    } muldiv_state_t;

    function automatic logic is_div(muldiv_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(muldiv_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_a(muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/cpu_muldiv_divider_core.sv
// cpu_muldiv_divider_core: iterative unsigned restoring divider, DIV_BITS quotient bits per cycle
module cpu_muldiv_divider_core #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder
);

    localparam int K  = XLEN / DIV_BITS;
    localparam int CW = $clog2(K + 1);

    logic [XLEN-1:0] quo, rem, dsr, quo_n, rem_n, d;
    logic [XLEN:0]   r, t;
    logic [CW-1:0]   cnt;

    // DIV_BITS restoring steps; the start cycle already runs the first step on the raw operands
    always_comb begin
        d     = i_start ? i_divisor : dsr;
        quo_n = i_start ? i_dividend : quo;
        rem_n = i_start ? '0 : rem;
        r     = '0;
        t     = '0;
        for (int i = 0; i < DIV_BITS; i++) begin
            r     = {rem_n, quo_n[XLEN-1]};
            t     = r - {1'b0, d};
            quo_n = {quo_n[XLEN-2:0], ~t[XLEN]};
            rem_n = t[XLEN] ? r[XLEN-1:0] : t[XLEN-1:0];
        end
    end

    // iterate until K steps are retired, then hold the result until the next start
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            quo <= '0;
            rem <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (i_start || !o_done) begin
            quo <= quo_n;
            rem <= rem_n;
            dsr <= d;
            cnt <= i_start ? CW'(1) : cnt + CW'(1);
        end
    end

    assign o_done      = cnt == CW'(K);
    assign o_quotient  = quo;
    assign o_remainder = rem;

endmodule

// File: rtl/cpu_execute_muldiv.sv
// cpu_execute_muldiv: multi-cycle RV32M/RV64M multiply/divide unit with valid/ready handshake
module cpu_execute_muldiv
    import cpu_muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1,
    parameter int TAG_WIDTH  = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  muldiv_op_t           i_op,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [XLEN-1:0]      i_op1,
    input  logic [XLEN-1:0]      i_op2,
    input  logic                 i_flush,
    input  logic                 i_stall,
    output logic                 o_valid,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic [XLEN-1:0]      o_result
);

    localparam int CW = $clog2(MUL_STAGES + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t        state;
    muldiv_op_t           op_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [CW-1:0]        cnt;
    logic                 negq_q, negr_q;
    logic                 acc, neg1, neg2, div0, ovf, fast, div_start, div_done;
    logic [XLEN-1:0]      fast_res, mag1, mag2, quo, rem, mul_res, div_res;
    logic [2*XLEN-1:0]    xa, xb, prod;
    logic [2*XLEN-1:0]    p [MUL_STAGES];

    // handshake, operand conditioning, fast-path detection and result selection
    always_comb begin
        o_ready   = state == ST_IDLE || (state == ST_DONE && !i_stall);
        acc       = i_valid && o_ready && !i_flush;
        neg1      = is_signed_a(i_op) && i_op1[XLEN-1];
        neg2      = is_signed_b(i_op) && i_op2[XLEN-1];
        div0      = i_op2 == '0;
        ovf       = is_signed_b(i_op) && i_op1 == MIN_NEG && &i_op2;
        fast      = is_div(i_op) && (div0 || ovf);
        fast_res  = is_rem(i_op) ? (div0 ? i_op1 : '0) : (div0 ? '1 : i_op1);
        mag1      = neg1 ? -i_op1 : i_op1;
        mag2      = neg2 ? -i_op2 : i_op2;
        div_start = acc && is_div(i_op) && !fast;
        xa        = {{XLEN{neg1}}, i_op1};
        xb        = {{XLEN{neg2}}, i_op2};
        prod      = xa * xb;
        mul_res   = op_q == OP_MUL ? p[MUL_STAGES-1][XLEN-1:0] : p[MUL_STAGES-1][2*XLEN-1:XLEN];
        div_res   = is_rem(op_q) ? (negr_q ? -rem : rem) : (negq_q ? -quo : quo);
    end

    // product captured at accept and then shifted so synthesis can retime the multiplier across it
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < MUL_STAGES; i++) p[i] <= '0;
        end else begin
            p[0] <= acc ? prod : p[0];
            for (int i = 1; i < MUL_STAGES; i++) p[i] <= p[i-1];
        end
    end

    cpu_muldiv_divider_core #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) u_div (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_start     (div_start),
        .i_dividend  (mag1),
        .i_divisor   (mag2),
        .o_done      (div_done),
        .o_quotient  (quo),
        .o_remainder (rem)
    );

    // control FSM with registered result; flush beats accept, accept beats normal progress
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_MUL;
            tag_q    <= '0;
            cnt      <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
        end else if (i_flush) begin
            state   <= ST_IDLE;
            o_valid <= 1'b0;
        end else if (acc) begin
            state    <= !is_div(i_op) ? ST_MUL : (fast ? ST_DONE : ST_DIV);
            op_q     <= i_op;
            tag_q    <= i_tag;
            cnt      <= CW'(1);
            negq_q   <= neg1 ^ neg2;
            negr_q   <= neg1;
            o_valid  <= fast;
            o_result <= fast ? fast_res : o_result;
            o_tag    <= fast ? i_tag : o_tag;
        end else begin
            case (state)
                ST_MUL: begin
                    if (cnt == CW'(MUL_STAGES)) begin
                        state    <= ST_DONE;
                        o_valid  <= 1'b1;
                        o_result <= mul_res;
                        o_tag    <= tag_q;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DIV: state <= div_done ? ST_FIX : ST_DIV;
                ST_FIX: begin
                    state    <= ST_DONE;
                    o_valid  <= 1'b1;
                    o_result <= div_res;
                    o_tag    <= tag_q;
                end
                ST_DONE: begin
                    if (!i_stall) begin
                        state   <= ST_IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_execute_muldiv.sv
// tb_cpu_execute_muldiv: vector table, random ops against a reference model, stall/flush/reset sequences
module tb_cpu_execute_muldiv;
    import cpu_muldiv_pkg::*;

    localparam int K  = 32;
    localparam int MS = 2;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_stall = 1'b0;
    logic        o_ready, o_valid;
    muldiv_op_t  i_op = OP_MUL;
    logic [7:0]  i_tag = '0;
    logic [7:0]  o_tag;
    logic [31:0] i_op1 = '0;
    logic [31:0] i_op2 = '0;
    logic [31:0] o_result;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 i_clock = ~i_clock;

    cpu_execute_muldiv #(.XLEN(32), .MUL_STAGES(MS), .DIV_BITS(1), .TAG_WIDTH(8)) dut (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_tag    (i_tag),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_flush  (i_flush),
        .i_stall  (i_stall),
        .o_valid  (o_valid),
        .o_tag    (o_tag),
        .o_result (o_result)
    );

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        logic [63:0] p;
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            default: begin
                if (b == 0) return (op == OP_DIV || op == OP_DIVU) ? 32'hFFFF_FFFF : a;
                if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return (op == OP_DIV) ? a : 32'h0;
                case (op)
                    OP_DIV:  p = sa / sb;
                    OP_REM:  p = sa % sb;
                    OP_DIVU: p = ua / ub;
                    default: p = ua % ub;
                endcase
                return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(muldiv_op_t op, logic [31:0] a, logic [31:0] b);
        if (!(op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU})) return MS + 1;
        if (b == 0) return 1;
        if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return K + 2;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic accept(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b, input logic [7:0] tag);
        int w = 0;
        while (!o_ready && w < 100) begin
            @(negedge i_clock);
            w++;
        end
        check("ready_wait", o_ready, 1);
        i_valid = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        i_tag   = tag;
        @(negedge i_clock);
        i_valid = 1'b0;
        i_op    = muldiv_op_t'($urandom_range(0, 7));
        i_op1   = $urandom;
        i_op2   = $urandom;
        i_tag   = 8'($urandom);
    endtask

    task automatic wait_result(output logic [31:0] res, output logic [7:0] tag, output int lat);
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge i_clock);
            lat++;
        end
        res = o_result;
        tag = o_tag;
    endtask

    task automatic run_check(input string name, input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                             input logic [7:0] tag, input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        logic [7:0]  tg;
        int          lat;
        accept(op, a, b, tag);
        wait_result(res, tg, lat);
        check({name, "_result"}, res, exp);
        check({name, "_tag"}, tg, tag);
        check({name, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] res, a, b;
        logic [7:0]  tg;
        int          lat, nv, st;
        muldiv_op_t  op;

        vecs[0]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3};
        vecs[1]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3};
        vecs[2]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3};
        vecs[3]  = '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 3};
        vecs[4]  = '{OP_MULH,   32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 3};
        vecs[5]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34};
        vecs[6]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34};
        vecs[7]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        34};
        vecs[8]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         34};
        vecs[9]  = '{OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         34};
        vecs[10] = '{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[11] = '{OP_REM,    32'd5,         32'd0,         32'd5,         1};
        vecs[12] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[13] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1};
        vecs[14] = '{OP_REMU,   32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1};

        repeat (2) @(negedge i_clock);
        check("reset_valid", o_valid, 0);
        check("reset_result", o_result, 0);
        check("reset_tag", o_tag, 0);
        check("reset_ready", o_ready, 1);
        i_reset = 1'b1;
        @(negedge i_clock);

        for (int i = 0; i < 15; i++)
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 8'(8'h10 + i), vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            op = muldiv_op_t'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_check($sformatf("rnd%0d", i), op, a, b, 8'(8'h80 + i), ref_result(op, a, b), ref_lat(op, a, b));
            st = $urandom_range(0, 2);
            if (st > 0) begin
                i_stall = 1'b1;
                repeat (st) @(negedge i_clock);
                check($sformatf("rnd%0d_stall_hold", i), {o_valid, o_result}, {1'b1, ref_result(op, a, b)});
                i_stall = 1'b0;
            end
        end

        accept(OP_MUL, 32'd6, 32'd7, 8'h40);
        wait_result(res, tg, lat);
        check("stall_first_result", res, 42);
        i_stall = 1'b1;
        i_valid = 1'b1;
        i_op    = OP_MUL;
        i_op1   = 32'd5;
        i_op2   = 32'd5;
        i_tag   = 8'h41;
        for (int c = 0; c < 3; c++) begin
            @(negedge i_clock);
            check($sformatf("stall%0d_valid", c), o_valid, 1);
            check($sformatf("stall%0d_result", c), o_result, 42);
            check($sformatf("stall%0d_tag", c), o_tag, 8'h40);
            check($sformatf("stall%0d_ready", c), o_ready, 0);
        end
        i_stall = 1'b0;
        #1;
        check("stall_release_ready", o_ready, 1);
        @(negedge i_clock);
        i_valid = 1'b0;
        wait_result(res, tg, lat);
        check("queued_mul_result", res, 25);
        check("queued_mul_tag", tg, 8'h41);
        check("queued_mul_latency", lat, 3);

        accept(OP_DIV, 32'd1000, 32'd3, 8'h50);
        repeat (9) @(negedge i_clock);
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_op    = OP_MUL;
        i_op1   = 32'd2;
        i_op2   = 32'd2;
        i_tag   = 8'h5F;
        @(negedge i_clock);
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("flush_ready", o_ready, 1);
        check("flush_valid", o_valid, 0);
        nv = 0;
        repeat (40) begin
            @(negedge i_clock);
            nv += int'(o_valid);
        end
        check("flush_no_result", nv, 0);
        run_check("post_flush_mulhu", OP_MULHU, 32'd3, 32'd4, 8'h51, 32'd0, 3);

        run_check("pre_reset_mul", OP_MUL, 32'd6, 32'd7, 8'h61, 32'd42, 3);
        accept(OP_DIV, 32'd1000, 32'd3, 8'h62);
        repeat (4) @(negedge i_clock);
        i_reset = 1'b0;
        #1;
        check("async_reset_valid", o_valid, 0);
        check("async_reset_result", o_result, 0);
        check("async_reset_tag", o_tag, 0);
        check("async_reset_ready", o_ready, 1);
        @(negedge i_clock);
        i_reset = 1'b1;
        run_check("post_reset_div", OP_DIV, 32'd9, 32'd3, 8'h63, 32'd3, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
